// File: rtl/rx_packet_fifo_if.sv
// Handshake bundle between the serial receiver, the packet FIFO and the router core.
// The slave modport is the FIFO's view. The master modport is the environment's view: receiver plus core.
interface rx_packet_fifo_if #(
    parameter int WIDTH      = 55,
    parameter int DEPTH_LOG2 = 2
);
    logic [WIDTH-1:0]    RX_Data;
    logic                RX_Data_Valid;
    logic                RX_Ready;
    logic [WIDTH-1:0]    Pkt_Data;
    logic                Pkt_Valid;
    logic                Pkt_Ready;
    logic [DEPTH_LOG2:0] Pkt_Count;
    logic                Overrun_Err;

    modport slave (
        input  RX_Data, RX_Data_Valid, Pkt_Ready,
        output RX_Ready, Pkt_Data, Pkt_Valid, Pkt_Count, Overrun_Err
    );

    modport master (
        output RX_Data, RX_Data_Valid, Pkt_Ready,
        input  RX_Ready, Pkt_Data, Pkt_Valid, Pkt_Count, Overrun_Err
    );
endinterface

// File: rtl/rx_packet_fifo.sv
// Circular first-word-fall-through packet FIFO between the serial receiver and the router core.
// It also runs a sticky watchdog that flags a receiver stalled against a full buffer.
module rx_packet_fifo #(
    parameter int WIDTH      = 55,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             Clk_S,
    input  logic             Rst,
    rx_packet_fifo_if.slave  bus
);
    localparam logic [DEPTH_LOG2:0] DEPTH      = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [10:0]         WDOG_LIMIT = 11'd1024;

    logic [WIDTH-1:0]      mem_q [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  rx_ready_q, rx_ready_d;
    logic [10:0]           wdog_q, wdog_d;
    logic                  overrun_q, overrun_d;
    logic                  push, pop, full;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        full       = (count_q == DEPTH);
        push       = bus.RX_Data_Valid && rx_ready_q;
        pop        = bus.Pkt_Ready && (count_q != '0);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        wdog_d     = '0;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;

        // The watchdog saturates at the limit, so a stall that never ends cannot wrap the counter back below the limit.
        if (full && bus.RX_Data_Valid)
            wdog_d = (wdog_q == WDOG_LIMIT) ? wdog_q : wdog_q + 1'b1;

        rx_ready_d = (count_d != DEPTH);
        overrun_d  = overrun_q || (wdog_d == WDOG_LIMIT);
    end

    always_ff @(posedge Clk_S) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (Rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rx_ready_q <= 1'b0;
            wdog_q     <= '0;
            overrun_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rx_ready_q <= rx_ready_d;
            wdog_q     <= wdog_d;
            overrun_q  <= overrun_d;
        end
    end

    // NOTE: the storage array has no reset. Clearing the count and pointers makes old entries unreachable, and the output is masked while empty.
    always_ff @(posedge Clk_S) begin
        if (push) mem_q[wr_ptr_q] <= bus.RX_Data;
    end

    assign bus.RX_Ready    = rx_ready_q;
    assign bus.Pkt_Valid   = (count_q != '0);
    assign bus.Pkt_Data    = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.Pkt_Count   = count_q;
    assign bus.Overrun_Err = overrun_q;
endmodule

// File: tb/tb_rx_packet_fifo.sv
// Self-checking bench for rx_packet_fifo: directed scenarios plus a randomized phase.
// Every cycle is scored against a queue-based reference model.
module tb_rx_packet_fifo;
    localparam int WIDTH      = 55;
    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic Clk_S = 1'b0;
    logic Rst   = 1'b1;

    rx_packet_fifo_if #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) bus_if ();

    rx_packet_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .Clk_S (Clk_S),
        .Rst   (Rst),
        .bus   (bus_if)
    );

    always #5 Clk_S = ~Clk_S;

    // Reference model: packet queue, accept flag, stall streak and sticky error.
    logic [WIDTH-1:0] mq[$];
    bit               rdy_m     = 1'b0;
    int               streak    = 0;
    bit               err_m     = 1'b0;
    bit               last_push = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [WIDTH-1:0] exp_data;
        exp_data = (mq.size() != 0) ? mq[0] : '0;
        check("rx_ready",    64'(bus_if.RX_Ready),    64'(rdy_m));
        check("pkt_valid",   64'(bus_if.Pkt_Valid),   64'(mq.size() != 0));
        check("pkt_count",   64'(bus_if.Pkt_Count),   64'(mq.size()));
        check("pkt_data",    64'(bus_if.Pkt_Data),    64'(exp_data));
        check("overrun_err", 64'(bus_if.Overrun_Err), 64'(err_m));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then score all outputs.
    task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit r, input bit rst);
        bit push_m;
        bit pop_m;
        bus_if.RX_Data_Valid = v;
        bus_if.RX_Data       = d;
        bus_if.Pkt_Ready     = r;
        Rst                  = rst;
        @(posedge Clk_S);
        if (rst) begin
            mq.delete();
            rdy_m     = 1'b0;
            streak    = 0;
            err_m     = 1'b0;
            last_push = 1'b0;
        end else begin
            push_m = v && rdy_m;
            pop_m  = r && (mq.size() != 0);
            if (mq.size() == DEPTH && v) streak++;
            else                         streak = 0;
            if (streak >= 1024) err_m = 1'b1;
            if (pop_m)  void'(mq.pop_front());
            if (push_m) mq.push_back(d);
            rdy_m     = (mq.size() < DEPTH);
            last_push = push_m;
        end
        #1;
        compare_all();
    endtask

    initial begin
        bit               cur_v;
        logic [WIDTH-1:0] cur_d;
        logic [63:0]      r64;
        logic [WIDTH-1:0] exp_order [4];

        bus_if.RX_Data_Valid = 1'b1;
        bus_if.RX_Data       = WIDTH'(7);
        bus_if.Pkt_Ready     = 1'b1;

        // Reset held with traffic requested on both sides
        for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(7), 1'b1, 1'b1);
        check("reset_data_zero", 64'(bus_if.Pkt_Data), 64'd0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("ready_after_reset", 64'(bus_if.RX_Ready), 64'd1);

        // Single packet
        step(1'b1, WIDTH'(3), 1'b0, 1'b0);
        check("single_valid", 64'(bus_if.Pkt_Valid), 64'd1);
        check("single_data",  64'(bus_if.Pkt_Data),  64'd3);
        check("single_count", 64'(bus_if.Pkt_Count), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("single_popped", 64'(bus_if.Pkt_Valid), 64'd0);

        // Fill, backpressure and wrap
        for (int i = 0; i < 4; i++) step(1'b1, WIDTH'(8'h11 + i), 1'b0, 1'b0);
        check("fill_count", 64'(bus_if.Pkt_Count), 64'd4);
        check("fill_ready", 64'(bus_if.RX_Ready),  64'd0);
        step(1'b1, WIDTH'(8'h15), 1'b0, 1'b0);
        step(1'b1, WIDTH'(8'h15), 1'b0, 1'b0);
        check("full_rejects", 64'(bus_if.Pkt_Count), 64'd4);
        step(1'b1, WIDTH'(8'h15), 1'b1, 1'b0);
        check("pop_from_full_count", 64'(bus_if.Pkt_Count), 64'd3);
        check("ready_after_pop",     64'(bus_if.RX_Ready),  64'd1);
        step(1'b1, WIDTH'(8'h15), 1'b0, 1'b0);
        check("fifth_accepted", 64'(bus_if.Pkt_Count), 64'd4);
        exp_order[0] = WIDTH'(8'h12);
        exp_order[1] = WIDTH'(8'h13);
        exp_order[2] = WIDTH'(8'h14);
        exp_order[3] = WIDTH'(8'h15);
        for (int i = 0; i < 4; i++) begin
            check("drain_order", 64'(bus_if.Pkt_Data), 64'(exp_order[i]));
            step(1'b0, '0, 1'b1, 1'b0);
        end

        // Simultaneous push and pop at count 2, then from empty
        step(1'b1, WIDTH'(8'h21), 1'b0, 1'b0);
        step(1'b1, WIDTH'(8'h22), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, WIDTH'(8'h30 + i), 1'b1, 1'b0);
            check("stream_count2", 64'(bus_if.Pkt_Count), 64'd2);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, WIDTH'(8'h40), 1'b1, 1'b0);
        check("empty_push_only", 64'(bus_if.Pkt_Count), 64'd1);
        for (int i = 0; i < 7; i++) step(1'b1, WIDTH'(8'h41 + i), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(8'h51 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        check("midrst_count", 64'(bus_if.Pkt_Count), 64'd0);
        check("midrst_valid", 64'(bus_if.Pkt_Valid), 64'd0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 55'h5A5A5A5A5A5A5A, 1'b0, 1'b0);
        check("post_rst_data", 64'(bus_if.Pkt_Data), 64'h5A5A5A5A5A5A5A);
        step(1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic; the receiver holds its packet until it is accepted
        cur_v = 1'b0;
        cur_d = '0;
        for (int i = 0; i < 400; i++) begin
            if (!cur_v || last_push) begin
                cur_v = ($urandom_range(0, 3) != 0);
                r64   = {$urandom(), $urandom()};
                cur_d = r64[WIDTH-1:0];
            end
            step(cur_v, cur_d, ($urandom_range(0, 2) != 0), ($urandom_range(0, 99) == 0));
        end

        // Watchdog
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, WIDTH'(8'h60 + i), 1'b0, 1'b0);
        for (int i = 0; i < 1023; i++) step(1'b1, WIDTH'(8'h64), 1'b0, 1'b0);
        check("wdog_1023", 64'(bus_if.Overrun_Err), 64'd0);
        step(1'b1, WIDTH'(8'h64), 1'b0, 1'b0);
        check("wdog_1024", 64'(bus_if.Overrun_Err), 64'd1);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("wdog_sticky", 64'(bus_if.Overrun_Err), 64'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("wdog_cleared", 64'(bus_if.Overrun_Err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
